// File: rtl/freq_meter.sv
// freq_meter: gated frequency meter counting rising edges of an async input over a fixed clk window
// Optional feature macro: FREQ_METER_HYST_EN (in_range needs 4 consecutive in-range windows to set)
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   en       run measurement windows back-to-back while high
//   meas_in  signal under measurement, asynchronous to clk
//   count    edge count of the last completed window
//   valid    one-cycle pulse when count updates
//   overflow last completed window saturated the edge counter
//   in_range range verdict of the last completed window(s)
module freq_meter #(
   parameter int GATE_CYCLES = 144000,
   parameter int CNT_W = 18,
   parameter logic [CNT_W-1:0] EXP_MIN = '0,
   parameter logic [CNT_W-1:0] EXP_MAX = {{(CNT_W-1){1'b1}}, 1'b0}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             meas_in,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             overflow,
   output logic             in_range
);
   localparam int GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SAT = '1;
   typedef enum logic {IDLE, GATE} state_t;
   state_t state, state_nx;
   logic s0, s1, dly, e;
   logic [GW-1:0] gcnt, gcnt_nx;
   logic [CNT_W-1:0] ecnt, ecnt_nx, ecnt_inc;
   logic ovf, ovf_nx, ovf_inc;
   logic last, publish, abort, raw;
   logic [CNT_W:0] lo_d, hi_d;
   assign e = s1 & ~dly;
   // count value including this cycle's edge, so the final gate cycle lands in its own window
   assign ecnt_inc = (e && ecnt != SAT) ? ecnt + CNT_W'(1) : ecnt;
   assign ovf_inc = ovf | (ecnt_inc == SAT);
   assign last = (state == GATE) && (gcnt == G_LAST);
   assign abort = (state == GATE) && !en;
   assign publish = last && en;
   // range test via borrow bits, so a zero EXP_MIN does not form a constant comparison
   assign lo_d = {1'b0, ecnt_inc} - {1'b0, EXP_MIN};
   assign hi_d = {1'b0, EXP_MAX} - {1'b0, ecnt_inc};
   assign raw = !ovf_inc && !lo_d[CNT_W] && !hi_d[CNT_W];
   always_comb begin
      state_nx = state;
      gcnt_nx = gcnt;
      ecnt_nx = ecnt;
      ovf_nx = ovf;
      if (state == IDLE) begin
         if (en) begin
            state_nx = GATE;
            gcnt_nx = '0;
            ecnt_nx = '0;
            ovf_nx = 1'b0;
         end
      end else if (!en) begin
         state_nx = IDLE;
      end else if (last) begin
         gcnt_nx = '0;
         ecnt_nx = '0;
         ovf_nx = 1'b0;
      end else begin
         gcnt_nx = gcnt + GW'(1);
         ecnt_nx = ecnt_inc;
         ovf_nx = ovf_inc;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {s0, s1, dly} <= 3'b000;
         state <= IDLE;
         gcnt <= '0;
         ecnt <= '0;
         ovf <= 1'b0;
         count <= '0;
         valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         {s0, s1, dly} <= {meas_in, s0, s1};
         state <= state_nx;
         gcnt <= gcnt_nx;
         ecnt <= ecnt_nx;
         ovf <= ovf_nx;
         valid <= publish;
         if (publish) begin
            count <= ecnt_inc;
            overflow <= ovf_inc;
         end
      end
   end
`ifdef FREQ_METER_HYST_EN
   logic [1:0] streak;
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= 2'd0;
         in_range <= 1'b0;
      end else if (abort) begin
         streak <= 2'd0;
      end else if (publish) begin
         if (!raw) begin
            streak <= 2'd0;
            in_range <= 1'b0;
         end else if (streak == 2'd3) begin
            in_range <= 1'b1;
         end else begin
            streak <= streak + 2'd1;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) in_range <= 1'b0;
      else if (publish) in_range <= raw;
   end
`endif
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table-driven, hand-sequenced and random checks of freq_meter against a sample-history model
module tb_freq_meter;
   localparam int G = 100;
   logic clk = 1'b0;
   logic rst = 1'b1, en = 1'b0, meas = 1'b0;
   logic [7:0] count8;
   logic valid8, ovf8, ir8;
   logic [3:0] count4;
   logic valid4, ovf4, ir4;
   int vecs = 0, errs = 0;
   int mode = 0, period = 10, ph = 0, lastp = -1;
   logic man = 1'b0;
   bit m [0:65535];
   int n = 2, start = 0;
   bit running = 0, chk_on = 0, exp_valid = 0;
   int exp_c [2], streak [2];
   bit exp_ov [2], exp_ir [2];
   int wmax [2] = '{255, 15};
   int lo [2] = '{9, 0};
   int hi [2] = '{11, 14};
   typedef struct {int period; int wins; int c8; int ir8; int c4; int ov4;} vec_t;
   vec_t tbl [5];

   freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .EXP_MIN(8'd9), .EXP_MAX(8'd11)) dut (
      .clk(clk), .rst(rst), .en(en), .meas_in(meas),
      .count(count8), .valid(valid8), .overflow(ovf8), .in_range(ir8));
   freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .meas_in(meas),
      .count(count4), .valid(valid4), .overflow(ovf4), .in_range(ir4));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int want);
      vecs++;
      if (act != want) begin
         errs++;
         if (errs <= 20) $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   // window ending at edge n counts rising transitions of the sampled input at edges start-1 .. n-2
   task automatic publish_model();
      int edges;
      bit raw;
      edges = 0;
      for (int j = start - 1; j <= n - 2; j++) if (m[j] && !m[j-1]) edges++;
      exp_valid = 1;
      for (int l = 0; l < 2; l++) begin
         exp_ov[l] = edges >= wmax[l];
         exp_c[l] = exp_ov[l] ? wmax[l] : edges;
         raw = !exp_ov[l] && exp_c[l] >= lo[l] && exp_c[l] <= hi[l];
`ifdef FREQ_METER_HYST_EN
         if (!raw) begin
            streak[l] = 0;
            exp_ir[l] = 0;
         end else if (streak[l] == 3) exp_ir[l] = 1;
         else streak[l]++;
`else
         exp_ir[l] = raw;
`endif
      end
   endtask

   initial forever begin
      @(posedge clk);
      n++;
      exp_valid = 0;
      if (rst) begin
         m[n] = 0; m[n-1] = 0; m[n-2] = 0;
         running = 0;
         chk_on = 1;
         for (int l = 0; l < 2; l++) begin
            exp_c[l] = 0; exp_ov[l] = 0; exp_ir[l] = 0; streak[l] = 0;
         end
      end else begin
         m[n] = meas;
         if (running && !en) begin
            running = 0;
            streak = '{0, 0};
         end else if (running && n == start + G) begin
            publish_model();
            start = n;
         end else if (!running && en) begin
            running = 1;
            start = n;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("valid8", valid8, exp_valid);
         chk("count8", count8, exp_c[0]);
         chk("ovf8", ovf8, exp_ov[0]);
         chk("in_range8", ir8, exp_ir[0]);
         chk("valid4", valid4, exp_valid);
         chk("count4", count4, exp_c[1]);
         chk("ovf4", ovf4, exp_ov[1]);
         chk("in_range4", ir4, exp_ir[1]);
      end
   end

   initial forever begin
      @(negedge clk);
      #1;
      if (mode == 1) meas = man;
      else if (mode == 2) meas = ($urandom_range(0, 2) == 0) ? ~meas : meas;
      else if (period == 0) meas = 1'b1;
      else begin
         if (period != lastp) ph = 0;
         lastp = period;
         meas = ph < period / 2;
         ph = (ph + 1) % period;
      end
   end

   task automatic wait_valid(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!valid8 && cyc < 400);
      if (!valid8) chk("valid_timeout", valid8, 1);
   endtask

   task automatic wait_n(input int tgt);
      int k;
      k = 0;
      while (n != tgt && k < 400) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      int cyc, held, seen;
      tbl[0] = '{10, 6, 10, 1, 10, 0};
      tbl[1] = '{20, 6, 5, 0, 5, 0};
      tbl[2] = '{10, 6, 10, 1, 10, 0};
      tbl[3] = '{4, 6, 25, 0, 15, 1};
      tbl[4] = '{0, 3, 0, 0, 0, 0};
      repeat (3) @(negedge clk);
      chk("rst_count", count8, 0);
      chk("rst_valid", valid8, 0);
      chk("rst_ovf", ovf8, 0);
      chk("rst_in_range", ir8, 0);
      rst = 0;
      en = 1;
      for (int i = 0; i < 5; i++) begin
         period = tbl[i].period;
         repeat (tbl[i].wins) wait_valid(cyc);
         chk("tbl_count8", count8, tbl[i].c8);
         chk("tbl_in_range8", ir8, tbl[i].ir8);
         chk("tbl_count4", count4, tbl[i].c4);
         chk("tbl_ovf4", ovf4, tbl[i].ov4);
      end
      man = 0;
      mode = 1;
      repeat (2) wait_valid(cyc);
      wait_n(start + 97);
      man = 1;
      wait_valid(cyc);
      chk("edge_last_cycle", count8, 1);
      man = 0;
      wait_n(start + 98);
      man = 1;
      wait_valid(cyc);
      chk("edge_after_end", count8, 0);
      man = 0;
      wait_valid(cyc);
      chk("edge_next_window", count8, 1);
      period = 10;
      mode = 0;
      repeat (2) wait_valid(cyc);
      held = count8;
      wait_n(start + 50);
      en = 0;
      seen = 0;
      repeat (150) begin
         @(negedge clk);
         if (valid8) seen++;
      end
      chk("abort_no_valid", seen, 0);
      chk("abort_hold", count8, held);
      en = 1;
      wait_valid(cyc);
      chk("reen_latency", cyc, G + 1);
      chk("reen_count", count8, 10);
      wait_n(start + 99);
      en = 0;
      @(negedge clk);
      chk("abort_last_cycle", valid8, 0);
      en = 1;
      mode = 2;
      repeat (3000) begin
         @(negedge clk);
         en = $urandom_range(0, 499) != 0;
      end
      en = 1;
      mode = 0;
      repeat (2) wait_valid(cyc);
      repeat (30) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("midrst_count8", count8, 0);
      chk("midrst_ovf8", ovf8, 0);
      chk("midrst_in_range8", ir8, 0);
      chk("midrst_count4", count4, 0);
      rst = 0;
      repeat (2) wait_valid(cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
